// File: rtl/score_keeper.sv
// score_keeper: judges lane presses against targets and expiries, keeps saturating hit/miss counts
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_state [2:0]   game state code from the top-level FSM
//   i_btn [3:0]     per-lane button level (synchronised, debounced)
//   i_target [3:0]  per-lane target present
//   i_target_expire one-cycle pulse, a target left the window unhit
//   o_score [3:0]   hit count, saturates at 15
//   o_miss [3:0]    miss count, saturates at MAX_MISS
//   o_hit_pulse     one-cycle strobe when score increments
//   o_miss_pulse    one-cycle strobe when miss increments
//   o_game_over     high while in OVER
module score_keeper #(
   parameter int unsigned MAX_MISS = 9,
   parameter int unsigned LOCKOUT  = 4,
   parameter logic [2:0]  ST_IDLE  = 3'b000,
   parameter logic [2:0]  ST_PLAY  = 3'b001,
   parameter logic [2:0]  ST_PAUSE = 3'b010
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [2:0] i_state,
   input  logic [3:0] i_btn,
   input  logic [3:0] i_target,
   input  logic       i_target_expire,
   output logic [3:0] o_score,
   output logic [3:0] o_miss,
   output logic       o_hit_pulse,
   output logic       o_miss_pulse,
   output logic       o_game_over
);
   localparam int unsigned LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_OVER} fsm_t;
   fsm_t r_fsm, w_fsm_nx;
   logic [3:0] r_btn_q, r_score, r_miss, w_score_nx, w_miss_nx, w_press;
   logic [LW-1:0] r_lock, w_lock_nx;
   logic r_hit_pulse, r_miss_pulse;
   logic w_judge, w_hit, w_wrong, w_score_inc, w_miss_inc;
   // presses are rising edges, suppressed entirely while the lockout runs
   assign w_press     = i_btn & ~r_btn_q & {4{r_lock == '0}};
   // ST_IDLE overrides everything, so no judging on the clearing edge
   assign w_judge     = (r_fsm == S_PLAY) && (i_state != ST_IDLE);
   assign w_hit       = |(w_press & i_target);
   assign w_wrong     = |(w_press & ~i_target);
   assign w_score_inc = w_judge && w_hit && (r_score != 4'd15);
   assign w_miss_inc  = w_judge && (w_wrong || i_target_expire) && (r_miss < 4'(MAX_MISS));
   always_comb begin
      w_fsm_nx   = r_fsm;
      w_score_nx = r_score + {3'd0, w_score_inc};
      w_miss_nx  = r_miss + {3'd0, w_miss_inc};
      w_lock_nx  = r_lock;
      if (w_judge)
         w_lock_nx = |w_press ? LW'(LOCKOUT) : ((r_lock != '0) ? r_lock - LW'(1) : r_lock);
      if (i_state == ST_IDLE) begin
         w_fsm_nx   = S_IDLE;
         w_score_nx = '0;
         w_miss_nx  = '0;
         w_lock_nx  = '0;
      end else begin
         case (r_fsm)
            S_IDLE:  w_fsm_nx = (i_state == ST_PLAY) ? S_PLAY : S_IDLE;
            // reaching the miss limit wins over a simultaneous pause request
            S_PLAY:  w_fsm_nx = (w_miss_inc && w_miss_nx == 4'(MAX_MISS)) ? S_OVER :
                                (i_state == ST_PAUSE) ? S_PAUSE : S_PLAY;
            S_PAUSE: w_fsm_nx = (i_state == ST_PLAY) ? S_PLAY : S_PAUSE;
            default: w_fsm_nx = S_OVER;
         endcase
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fsm        <= S_IDLE;
         r_btn_q      <= 4'hF;
         r_score      <= '0;
         r_miss       <= '0;
         r_lock       <= '0;
         r_hit_pulse  <= 1'b0;
         r_miss_pulse <= 1'b0;
      end else begin
         r_fsm        <= w_fsm_nx;
         r_btn_q      <= i_btn;
         r_score      <= w_score_nx;
         r_miss       <= w_miss_nx;
         r_lock       <= w_lock_nx;
         r_hit_pulse  <= w_score_inc;
         r_miss_pulse <= w_miss_inc;
      end
   end
   assign o_score      = r_score;
   assign o_miss       = r_miss;
   assign o_hit_pulse  = r_hit_pulse;
   assign o_miss_pulse = r_miss_pulse;
   assign o_game_over  = (r_fsm == S_OVER);
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed stimulus, spec-level model with per-cycle compare, literal checkpoints
module tb_score_keeper;
   localparam int MAXM = 9;
   localparam int LOCK = 4;
   localparam logic [2:0] SI = 3'b000, SP = 3'b001, SZ = 3'b010;
   localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;
   logic clk = 1'b0, rst_n;
   logic [2:0] st;
   logic [3:0] btn, target, score, miss;
   logic expire, hp, mp, go;
   int tests = 0, fails = 0;
   int m_mode, m_score, m_miss, m_lock;
   logic [3:0] m_prev, m_pr;
   bit m_hp, m_mp;
   score_keeper #(.MAX_MISS(MAXM), .LOCKOUT(LOCK)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_state(st), .i_btn(btn), .i_target(target),
      .i_target_expire(expire), .o_score(score), .o_miss(miss), .o_hit_pulse(hp),
      .o_miss_pulse(mp), .o_game_over(go)
   );
   always #5 clk = ~clk;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_IDLE; m_score = 0; m_miss = 0; m_lock = 0;
         m_prev = 4'hF; m_hp = 0; m_mp = 0;
      end else begin
         m_pr = btn & ~m_prev;
         m_prev = btn;
         m_hp = 0; m_mp = 0;
         if (st == SI) begin
            m_mode = M_IDLE; m_score = 0; m_miss = 0; m_lock = 0;
         end else if (m_mode == M_PLAY) begin
            if (m_lock > 0) begin
               m_pr = 4'h0;
               m_lock = m_lock - 1;
            end
            if (m_pr != 0) m_lock = LOCK;
            if ((m_pr & target) != 0 && m_score < 15) begin m_score++; m_hp = 1; end
            if (((m_pr & ~target) != 0 || expire) && m_miss < MAXM) begin m_miss++; m_mp = 1; end
            if (m_mp && m_miss == MAXM) m_mode = M_OVER;
            else if (st == SZ) m_mode = M_PAUSE;
         end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && st == SP) m_mode = M_PLAY;
      end
   end
   always @(negedge clk) begin
      tests++;
      if (score !== 4'(m_score) || miss !== 4'(m_miss) || hp !== m_hp || mp !== m_mp ||
          go !== (m_mode == M_OVER)) begin
         fails++;
         $display("FAIL cycle t=%0t: got score=%0d miss=%0d hp=%b mp=%b go=%b, want %0d %0d %b %b %b",
                  $time, score, miss, hp, mp, go, m_score, m_miss, m_hp, m_mp, m_mode == M_OVER);
      end
   end
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask
   task automatic step(input logic [3:0] b, input logic [3:0] t, input logic e);
      btn = b; target = t; expire = e;
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'h0, 4'h0, 1'b0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      rst_n = 1'b0; st = SP; btn = 4'b0001; target = 4'b0001; expire = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_score", score, 0); chk("rst_miss", miss, 0); chk("rst_go", go, 0);
      rst_n = 1'b1;
      step(4'b0001, 4'b0001, 1'b0);
      step(4'b0001, 4'b0001, 1'b0);
      chk("held_btn_no_hit", score, 0);
      step(4'b0000, 4'b0001, 1'b0);
      step(4'b0001, 4'b0001, 1'b0);
      chk("t1_score", score, 1); chk("t1_hp", hp, 1); chk("t1_miss", miss, 0);
      step(4'b0001, 4'b0001, 1'b0);
      chk("t1_hp_once", hp, 0);
      idle(5);
      step(4'b0100, 4'h0, 1'b0);
      chk("t2_miss1", miss, 1); chk("t2_mp", mp, 1);
      idle(1);
      step(4'b0100, 4'h0, 1'b0);
      chk("t2_locked", miss, 1); chk("t2_locked_mp", mp, 0);
      idle(2);
      step(4'b0100, 4'h0, 1'b0);
      chk("t2_miss2", miss, 2);
      idle(5);
      step(4'b0011, 4'b0001, 1'b1);
      chk("t3_score", score, 2); chk("t3_miss", miss, 3);
      chk("t3_pulses", {hp, mp}, 3);
      idle(5);
      st = SI; idle(1);
      chk("t4_clear_miss", miss, 0);
      st = SP; idle(1);
      for (int i = 1; i <= 9; i++) begin
         step(4'h0, 4'h0, 1'b1);
         chk("t4_miss", miss, i);
         chk("t4_go", go, i == 9);
      end
      step(4'b0001, 4'b0001, 1'b1);
      chk("t4_frozen_score", score, 0); chk("t4_frozen_miss", miss, 9);
      st = SI; idle(1);
      chk("t4_idle_go", go, 0); chk("t4_idle_miss", miss, 0);
      st = SP; idle(1);
      for (int i = 1; i <= 16; i++) begin
         step(4'b0001, 4'b0001, 1'b0);
         chk("t5_score", score, (i < 15) ? i : 15);
         chk("t5_hp", hp, i <= 15);
         idle(5);
      end
      st = SZ; idle(1);
      step(4'b0010, 4'h0, 1'b1);
      idle(1);
      step(4'b0001, 4'b0001, 1'b0);
      chk("t6_pause_score", score, 15); chk("t6_pause_miss", miss, 0);
      st = SP; idle(6);
      step(4'b0100, 4'h0, 1'b0);
      chk("t6_play_miss", miss, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_score", score, 0); chk("t6_rst_miss", miss, 0);
      chk("t6_rst_pulse", mp, 0); chk("t6_rst_go", go, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
